multi_debouncer: RTL and testbench

- Parametrised N-channel debouncer for the board's buttons and switches.
- Each raw input goes through an optional polarity inversion, a 2-flop synchroniser and a per-channel stability counter.
- Each channel then drives a per-channel press FSM with five outputs: the clean level, press and release strobes, a one-shot long-press strobe and an auto-repeat strobe.
- The block sits between the FPGA pins and the UI/control logic.

---
 rtl/multi_debouncer.sv | 141 ++++++++++++++
 tb/tb_multi_debouncer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multi_debouncer.sv
// multi_debouncer: N-channel synchronise + debounce front end with
// press/release/long-press/auto-repeat strobes per channel.
module multi_debouncer #(
  parameter int NUM_CH = 4,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW_MASK = '0
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [NUM_CH-1:0] dirty_in,
  output logic [NUM_CH-1:0] clean_out,
  output logic [NUM_CH-1:0] press_out,
  output logic [NUM_CH-1:0] release_out,
  output logic [NUM_CH-1:0] long_out,
  output logic [NUM_CH-1:0] repeat_out
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW =
    (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;
  localparam int R_LIM =
    (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;
  localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] R_MAX = RW'(R_LIM);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } state_e;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic          s1_q, s1_d, s2_q, s2_d;
    logic          clean_q, clean_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          press_q, press_d, rel_q, rel_d;
    logic          long_q, long_d, rep_q, rep_d;
    state_e        st_q, st_d;

    always_comb begin
      s1_d    = dirty_in[i] ^ ACTIVE_LOW_MASK[i];
      s2_d    = s1_q;
      clean_d = clean_q;
      dcnt_d  = '0;
      if (s2_q != clean_q) begin
        if (dcnt_q == D_MAX) clean_d = s2_q;
        else dcnt_d = dcnt_q + 1'b1;
      end
    end

    // FSM looks at clean_d so strobes line up with the new clean level
    always_comb begin
      st_d    = st_q;
      hcnt_d  = hcnt_q;
      rcnt_d  = rcnt_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      long_d  = 1'b0;
      rep_d   = 1'b0;
      unique case (st_q)
        IDLE: begin
          if (clean_d) begin
            st_d    = PRESSED;
            press_d = 1'b1;
            hcnt_d  = '0;
          end
        end
        PRESSED: begin
          if (!clean_d) begin
            st_d   = IDLE;
            rel_d  = 1'b1;
            hcnt_d = '0;
          end else if (hcnt_q == H_MAX) begin
            st_d   = HELD;
            long_d = 1'b1;
            rcnt_d = '0;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!clean_d) begin
            st_d   = IDLE;
            rel_d  = 1'b1;
            hcnt_d = '0;
            rcnt_d = '0;
          end else if (REPEAT_CYCLES > 0) begin
            if (rcnt_q == R_MAX) begin
              rep_d  = 1'b1;
              rcnt_d = '0;
            end else begin
              rcnt_d = rcnt_q + 1'b1;
            end
          end
        end
        default: st_d = IDLE;
      endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        clean_q <= 1'b0;
        dcnt_q  <= '0;
        hcnt_q  <= '0;
        rcnt_q  <= '0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
        rep_q   <= 1'b0;
        st_q    <= IDLE;
      end else begin
        s1_q    <= s1_d;
        s2_q    <= s2_d;
        clean_q <= clean_d;
        dcnt_q  <= dcnt_d;
        hcnt_q  <= hcnt_d;
        rcnt_q  <= rcnt_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        long_q  <= long_d;
        rep_q   <= rep_d;
        st_q    <= st_d;
      end
    end

    assign clean_out[i]   = clean_q;
    assign press_out[i]   = press_q;
    assign release_out[i] = rel_q;
    assign long_out[i]    = long_q;
    assign repeat_out[i]  = rep_q;
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer: randomized + directed stimulus, timestamp-based
// reference model, queue scoreboard checked by an independent monitor.
module tb_multi_debouncer;

  localparam int N = 4;
  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 3;
  localparam logic [N-1:0] MASK = 4'b1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] dirty_in = MASK;
  logic [N-1:0] c1, p1, r1, l1, rp1;
  logic [N-1:0] c2, p2, r2, l2, rp2;

  always #5 clk = ~clk;

  multi_debouncer #(
    .NUM_CH(N), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R), .ACTIVE_LOW_MASK(MASK)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .dirty_in(dirty_in),
    .clean_out(c1), .press_out(p1), .release_out(r1),
    .long_out(l1), .repeat_out(rp1)
  );

  multi_debouncer #(
    .NUM_CH(N), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H),
    .REPEAT_CYCLES(0), .ACTIVE_LOW_MASK(MASK)
  ) dut_norep (
    .clk_in(clk), .rst_n_in(rst_n), .dirty_in(dirty_in),
    .clean_out(c2), .press_out(p2), .release_out(r2),
    .long_out(l2), .repeat_out(rp2)
  );

  typedef struct packed {
    logic [N-1:0] c;
    logic [N-1:0] p;
    logic [N-1:0] r;
    logic [N-1:0] l;
    logic [N-1:0] rp;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  // model state: pipeline values, edge of last s2 change, press edge
  int t = 0;
  logic m_s1[N];
  logic m_s2[N];
  logic m_cl[N];
  int chg[N];
  int pt[N];

  task automatic model_step(input logic [N-1:0] d, input logic r,
                            output exp_t e);
    int age;
    e = '0;
    t++;
    for (int i = 0; i < N; i++) begin
      if (!r) begin
        m_s1[i] = 1'b0;
        m_s2[i] = 1'b0;
        m_cl[i] = 1'b0;
        chg[i] = t;
      end else begin
        if (m_s2[i] != m_cl[i] && t - chg[i] >= D) begin
          m_cl[i] = m_s2[i];
          if (m_cl[i]) begin
            e.p[i] = 1'b1;
            pt[i] = t;
          end else begin
            e.r[i] = 1'b1;
          end
        end else if (m_cl[i]) begin
          age = t - pt[i];
          if (age == H) e.l[i] = 1'b1;
          if (age > H && (age - H) % R == 0) e.rp[i] = 1'b1;
        end
        e.c[i] = m_cl[i];
        if (m_s1[i] != m_s2[i]) chg[i] = t;
        m_s2[i] = m_s1[i];
        m_s1[i] = d[i] ^ MASK[i];
      end
    end
  endtask

  task automatic step(input logic [N-1:0] d, input logic r);
    exp_t e;
    @(negedge clk);
    dirty_in = d;
    rst_n = r;
    model_step(d, r, e);
    q.push_back(e);
  endtask

  task automatic idle(input logic [N-1:0] d, input int n);
    for (int k = 0; k < n; k++) step(d, 1'b1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_chk++;
        if ({c1, p1, r1, l1, rp1} !== e) begin
          n_fail++;
          $display("FAIL main t=%0d got c=%b p=%b r=%b l=%b rp=%b exp c=%b p=%b r=%b l=%b rp=%b",
                   t, c1, p1, r1, l1, rp1, e.c, e.p, e.r, e.l, e.rp);
        end
        n_chk++;
        if ({c2, p2, r2, l2, rp2} !== {e.c, e.p, e.r, e.l, 4'b0000}) begin
          n_fail++;
          $display("FAIL norep t=%0d got c=%b p=%b r=%b l=%b rp=%b exp c=%b p=%b r=%b l=%b rp=0000",
                   t, c2, p2, r2, l2, rp2, e.c, e.p, e.r, e.l);
        end
      end
    end
  end

  initial begin : stim
    logic [N-1:0] d;
    logic [N-1:0] lvl;
    int rem[N];
    logic rr;
    for (int i = 0; i < N; i++) begin
      m_s1[i] = 1'b0;
      m_s2[i] = 1'b0;
      m_cl[i] = 1'b0;
      chg[i] = 0;
      pt[i] = 0;
      rem[i] = 0;
    end
    for (int k = 0; k < 3; k++) step(MASK, 1'b0);
    idle(MASK, 5);
    idle(MASK | 4'b0001, 40);
    idle(MASK, 15);
    for (int k = 0; k < 30; k++) begin
      d = MASK;
      d[1] = ((k % 5) < 3);
      step(d, 1'b1);
    end
    idle(MASK, 10);
    idle(MASK | 4'b0100, 12);
    idle(MASK, 15);
    idle(4'b0000, 20);
    idle(MASK, 15);
    idle(4'b0111, 22);
    idle(4'b0110, 15);
    idle(MASK, 15);
    idle(MASK | 4'b0001, 20);
    for (int k = 0; k < 3; k++) step(MASK | 4'b0001, 1'b0);
    idle(MASK | 4'b0001, 25);
    idle(MASK, 15);
    lvl = MASK;
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0) begin
          lvl[i] = logic'($urandom_range(0, 1));
          rem[i] = ($urandom_range(0, 3) == 0) ?
                   int'($urandom_range(15, 40)) :
                   int'($urandom_range(1, 8));
        end
        rem[i]--;
      end
      rr = ($urandom_range(0, 299) != 0);
      step(lvl, rr);
    end
    idle(MASK, 20);
    @(posedge clk);
    #3;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
